// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix loader and multiplier: default sizes and
// the loader FSM state enumeration.
package matrix_pkg;

    localparam int unsigned MAT_DATA_W = 8;
    localparam int unsigned MAT_N      = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        HOLD
    } state_t;

endpackage

// File: rtl/matrix_reg_bank.sv
// DEPTH x DATA_W register bank with a single indexed write port and the
// whole contents exposed as one flattened read bus (entry k at [k*DATA_W +: DATA_W]).
module matrix_reg_bank
    import matrix_pkg::*;
#(
    parameter int unsigned DATA_W = MAT_DATA_W,
    parameter int unsigned DEPTH  = MAT_N * MAT_N
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   idx,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DEPTH*DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_read
        assign rdata[g*DATA_W +: DATA_W] = mem[g];
    end

endmodule

// File: rtl/matrix_data_loader.sv
// Serial loader that collects matrix A then matrix B (row-major) and holds the
// pair for the downstream multiplier until it is consumed.
module matrix_data_loader
    import matrix_pkg::*;
#(
    parameter int unsigned DATA_W = MAT_DATA_W,
    parameter int unsigned N      = MAT_N
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    start,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N*N*DATA_W-1:0]   mat_a,
    output logic [N*N*DATA_W-1:0]   mat_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int unsigned NE    = N * N;
    localparam int unsigned CNT_W = $clog2(NE);

    typedef logic [CNT_W-1:0] cnt_t;

    state_t state, state_next;
    cnt_t   cnt, cnt_next;
    logic   beat, last, we_a, we_b;

    assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign beat      = in_valid && in_ready;
    assign last      = (cnt == cnt_t'(NE - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // start during a load wins over a coincident beat, which is dropped
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        we_a       = 1'b0;
        we_b       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD_A;
                    cnt_next   = '0;
                end
            end
            LOAD_A: begin
                if (start) begin
                    cnt_next = '0;
                end else if (beat) begin
                    we_a = 1'b1;
                    if (last) begin
                        state_next = LOAD_B;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + cnt_t'(1);
                    end
                end
            end
            LOAD_B: begin
                if (start) begin
                    state_next = LOAD_A;
                    cnt_next   = '0;
                end else if (beat) begin
                    we_b = 1'b1;
                    if (last) begin
                        state_next = HOLD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + cnt_t'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = start ? LOAD_A : IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    matrix_reg_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (NE)
    ) u_bank_a (
        .CLK   (CLK),
        .RST_N (RST_N),
        .we    (we_a),
        .idx   (cnt),
        .wdata (in_data),
        .rdata (mat_a)
    );

    matrix_reg_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (NE)
    ) u_bank_b (
        .CLK   (CLK),
        .RST_N (RST_N),
        .we    (we_b),
        .idx   (cnt),
        .wdata (in_data),
        .rdata (mat_b)
    );

endmodule

// File: tb/tb_matrix_data_loader.sv
// Self-checking bench for matrix_data_loader: directed scenarios plus random
// traffic, compared against an element-count based reference model.
module tb_matrix_data_loader;

    localparam int DW     = 8;
    localparam int DIM    = 2;
    localparam int NE     = DIM * DIM;
    localparam int FLAT_W = NE * DW;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              start = 1'b0;
    logic [DW-1:0]     in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [FLAT_W-1:0] mat_a;
    logic [FLAT_W-1:0] mat_b;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;

    matrix_data_loader #(
        .DATA_W (DW),
        .N      (DIM)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mat_a     (mat_a),
        .mat_b     (mat_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: m_k counts elements accepted since the last start
    // (0..NE-1 -> A, NE..2NE-1 -> B, 2NE -> pair complete and held).
    bit            m_active;
    int            m_k;
    logic [DW-1:0] m_a [NE];
    logic [DW-1:0] m_b [NE];

    task automatic model_reset();
        m_active = 0;
        m_k      = 0;
        for (int i = 0; i < NE; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
        end
    endtask

    function automatic logic [FLAT_W-1:0] pack(input logic [DW-1:0] arr [NE]);
        logic [FLAT_W-1:0] r;
        r = '0;
        for (int i = 0; i < NE; i++) r[i*DW +: DW] = arr[i];
        return r;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".in_ready"},  64'(in_ready),  64'(m_active && m_k < 2*NE));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(m_active && m_k == 2*NE));
        check({tag, ".busy"},      64'(busy),      64'(m_active));
        check({tag, ".mat_a"},     64'(mat_a),     64'(pack(m_a)));
        check({tag, ".mat_b"},     64'(mat_b),     64'(pack(m_b)));
    endtask

    task automatic model_update(input logic s, input logic v, input logic [DW-1:0] d, input logic r);
        if (!m_active) begin
            if (s) begin
                m_active = 1;
                m_k      = 0;
            end
        end else if (m_k < 2*NE) begin
            if (s) begin
                m_k = 0;
            end else if (v) begin
                if (m_k < NE) m_a[m_k] = d;
                else          m_b[m_k-NE] = d;
                m_k++;
            end
        end else if (r) begin
            if (s) m_k = 0;
            else   m_active = 0;
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance both.
    task automatic step(input logic s, input logic v, input logic [DW-1:0] d, input logic r);
        start     = s;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        compare_all("cyc");
        model_update(s, v, d, r);
        @(posedge CLK);
        #1;
    endtask

    logic [DW-1:0] nom [2*NE] = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd1, 8'd2, 8'd3, 8'd4};

    task automatic load_nominal(input bit do_start, input bit gapped);
        if (do_start) step(1'b1, 1'b0, DW'($urandom), 1'b0);
        for (int i = 0; i < 2*NE; i++) begin
            if (gapped) step(1'b0, 1'b0, DW'($urandom), 1'b0);
            if (i == 2*NE-1) check("pre_last.out_valid", 64'(out_valid), 64'd0);
            step(1'b0, 1'b1, nom[i], 1'b0);
        end
        check("lat.out_valid", 64'(out_valid), 64'd1);
        check("nom.mat_a", 64'(mat_a), 64'h0202_0202);
        check("nom.mat_b", 64'(mat_b), 64'h0403_0201);
    endtask

    initial begin
        model_reset();
        #1;
        check("rst.in_ready",  64'(in_ready),  64'd0);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.busy",      64'(busy),      64'd0);
        check("rst.mat_a",     64'(mat_a),     64'd0);
        check("rst.mat_b",     64'(mat_b),     64'd0);
        #11 RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Nominal load, then backpressure for 5 cycles before release.
        load_nominal(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp.out_valid", 64'(out_valid), 64'd1);
            check("bp.in_ready",  64'(in_ready),  64'd0);
            step(1'b0, 1'b1, DW'($urandom), 1'b0);
        end
        check("bp6.out_valid", 64'(out_valid), 64'd1);
        step(1'b0, 1'b0, '0, 1'b1);
        check("bp_done.out_valid", 64'(out_valid), 64'd0);

        // Gapped valid.
        load_nominal(1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Restart after three beats with a discarded coincident beat.
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'd9, 1'b0);
        step(1'b1, 1'b1, 8'd7, 1'b0);
        load_nominal(1'b0, 1'b0);

        // Back-to-back handoff and restart.
        step(1'b1, 1'b0, '0, 1'b1);
        check("b2b.out_valid", 64'(out_valid), 64'd0);
        check("b2b.in_ready",  64'(in_ready),  64'd1);
        check("b2b.busy",      64'(busy),      64'd1);
        for (int i = 0; i < 2*NE; i++) step(1'b0, 1'b1, DW'($urandom), 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);

        // Reset mid-load after five beats, asserted away from any edge.
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DW'($urandom_range(1, 255)), 1'b0);
        #2 RST_N = 1'b0;
        #1;
        model_reset();
        check("arst.in_ready",  64'(in_ready),  64'd0);
        check("arst.out_valid", 64'(out_valid), 64'd0);
        check("arst.busy",      64'(busy),      64'd0);
        check("arst.mat_a",     64'(mat_a),     64'd0);
        check("arst.mat_b",     64'(mat_b),     64'd0);
        @(posedge CLK);
        @(posedge CLK);
        #3 RST_N = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("post_rst.busy", 64'(busy), 64'd0);
            step(1'b0, 1'b1, DW'($urandom), 1'($urandom));
        end

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 9) < 7),
                 DW'($urandom),
                 1'($urandom_range(0, 9) < 4));
        end
        compare_all("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_data_loader.md
MATRIX_DATA_LOADER -- requirements
Module: matrix_data_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning width of one matrix element (unsigned).
REQ-002 SHALL have parameter N, default 2, meaning matrix dimension (N x N); legal values 2..4.
REQ-003 SHALL have port CLK  input  1  system clock, rising-edge active.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset; this is the block's only clock and only reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse that begins a new load of matrix A then matrix B.
REQ-006 SHALL have port in_data  input  DATA_W  serial element stream, row-major, A first then B.
REQ-007 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-008 SHALL have port in_ready  output  1  loader accepts an element this cycle.
REQ-009 SHALL have port mat_a  output  N*N*DATA_W  matrix A flattened; element k (row-major) at [k*DATA_W +: DATA_W].
REQ-010 SHALL have port mat_b  output  N*N*DATA_W  matrix B, same layout as mat_a.
REQ-011 SHALL have port out_valid  output  1  mat_a/mat_b hold a complete pair for the downstream multiplier.
REQ-012 SHALL have port out_ready  input  1  downstream multiplier consumes the pair.
REQ-013 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD_A, LOAD_B, HOLD.
REQ-015 SHALL define a beat as a rising CLK edge where in_valid=1 and in_ready=1.
REQ-016 SHALL drive in_ready=1 only in LOAD_A and LOAD_B, combinationally from state alone (no dependence on in_valid).
REQ-017 SHALL, in IDLE, go to LOAD_A on start=1 with element counter cleared to 0; all other inputs ignored.
REQ-018 SHALL, in LOAD_A, on each beat write in_data into A element [counter] and increment counter; the beat at counter=N*N-1 moves to LOAD_B with counter=0.
REQ-019 SHALL, in LOAD_B, behave identically into B; the beat at counter=N*N-1 moves to HOLD.
REQ-020 SHALL assert out_valid in the cycle after the final B beat (latency 1) and hold it high through HOLD.
REQ-021 SHALL keep mat_a/mat_b stable while out_valid=1.
REQ-022 SHALL, in HOLD, go to IDLE when out_ready=1; out_valid falls on the next cycle.
REQ-023 SHALL, in HOLD with out_ready=1 and start=1 in the same cycle, complete the handoff and go directly to LOAD_A with counter=0.
REQ-024 SHALL ignore start in HOLD while out_ready=0.
REQ-025 SHALL, on start=1 in LOAD_A or LOAD_B, restart in LOAD_A with counter=0; any beat in that same cycle is discarded.
REQ-026 SHALL leave A/B registers unchanged by a restart; stale contents are overwritten by new beats and never flagged by out_valid.
REQ-027 SHALL size the counter as $clog2(N*N) bits; the counter never exceeds N*N-1.
REQ-028 SHALL store elements verbatim, with no arithmetic, truncation or sign extension.

Reset
REQ-029 SHALL, on RST_N=0, immediately force state=IDLE, counter=0, all A/B registers=0, in_ready=0, out_valid=0, busy=0.
REQ-030 SHALL abandon any load or pending handoff when reset asserts mid-operation; after release the block waits in IDLE for start.

Structure
REQ-031 SHALL take DATA_W/N defaults and the FSM state enumeration from shared package matrix_pkg, which the multiplier also uses.
REQ-032 SHALL instantiate sub-module matrix_reg_bank (N*N x DATA_W, write-enable plus index, flattened read) twice, once for A and once for B.

Verification
REQ-033 SHALL cover nominal load: start, then 8 contiguous beats 2,2,2,2,1,2,3,4 -> out_valid one cycle after the 8th beat; mat_a elements = {2,2,2,2}; mat_b elements = {1,2,3,4}.
REQ-034 SHALL cover gapped valid: the same data with in_valid low every other cycle -> identical mat_a/mat_b; out_valid 1 cycle after the last beat.
REQ-035 SHALL cover backpressure: out_ready held 0 for 5 cycles, then 1 -> out_valid high all 6 cycles, then low; in_ready=0 throughout HOLD.
REQ-036 SHALL cover restart: start, beats 9,9,9, then start with in_valid=1 data 7, then 8 beats 2,2,2,2,1,2,3,4 -> value 7 discarded; mat_a={2,2,2,2}, mat_b={1,2,3,4}.
REQ-037 SHALL cover back-to-back: out_ready=1 and start=1 in the same HOLD cycle -> next cycle in LOAD_A, out_valid=0, in_ready=1.
REQ-038 SHALL cover reset mid-load: RST_N low after 5 beats -> all outputs 0 asynchronously; after release, busy=0 until the next start.
